// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// load-use interlock, branch/jump resolution and a RUN/HALTED/ERROR state machine.
module pipe_ctrl_unit #(
  parameter int REG_AW         = 4,
  parameter int CNT_W          = 16,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        opcode,
  input  logic [3:0]        function_code,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        branch_result,
  input  logic              overflow_flag,
  input  logic              resume,
  output logic              pc_op,
  output logic              b_jmp,
  output logic              if_flush,
  output logic              id_flush,
  output logic              stall,
  output logic              ex_flush,
  output logic              halt,
  output logic              overflow_error_warning,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src_a,
  output logic              ex_alu_src_b,
  output logic              ex_r0_select,
  output logic              mem_byte_en,
  output logic              mem_write,
  output logic              wb_mux_c,
  output logic [1:0]        wb_reg_write,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_LBU   = 4'b1010;
  localparam logic [3:0] OP_SB    = 4'b1011;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_ATYPE = 4'b1111;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HALTED = 2'd1, ST_ERROR = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]        alu_op;
    logic              alu_src_a;
    logic              alu_src_b;
    logic              r0_select;
    logic              byte_en;
    logic              mem_write;
    logic              mux_c;
    logic [1:0]        reg_write;
    logic              is_load;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  // Later stages only keep the fields they still need.
  typedef struct packed {
    logic       byte_en;
    logic       mem_write;
    logic       mux_c;
    logic [1:0] reg_write;
  } ex_mem_t;

  typedef struct packed {
    logic       mux_c;
    logic [1:0] reg_write;
  } mem_wb_t;

  state_t           state_reg, state_next;
  id_ex_t           decoded, id_ex_reg;
  ex_mem_t          ex_mem_reg;
  mem_wb_t          mem_wb_reg;
  logic             halt_reg, warn_reg, ex_flush_reg;
  logic [CNT_W-1:0] count_reg;
  logic             bubble, count_en, hazard, branch_taken;

  always_comb begin
    decoded    = '0;
    decoded.rd = id_rd;
    case (opcode)
      OP_ATYPE: begin
        decoded.alu_op = 2'b01;
        decoded.mux_c  = 1'b1;
        if (function_code == 4'b1000 || function_code == 4'b0100)
          decoded.reg_write = 2'b11;
        else if (function_code == 4'b0001 || function_code == 4'b0010)
          decoded.reg_write = 2'b10;
      end
      OP_ANDI, OP_ORI: begin
        decoded.alu_op    = (opcode == OP_ORI) ? 2'b10 : 2'b00;
        decoded.alu_src_b = 1'b1;
        decoded.reg_write = 2'b10;
        decoded.mux_c     = 1'b1;
      end
      OP_LBU, OP_LW: begin
        decoded.alu_op    = 2'b11;
        decoded.alu_src_a = 1'b1;
        decoded.reg_write = 2'b10;
        decoded.is_load   = 1'b1;
        decoded.byte_en   = (opcode == OP_LBU);
      end
      OP_SB, OP_SW: begin
        decoded.alu_op    = 2'b11;
        decoded.alu_src_a = 1'b1;
        decoded.mem_write = 1'b1;
        decoded.byte_en   = (opcode == OP_SB);
      end
      OP_BLT, OP_BGT, OP_BEQ: decoded.r0_select = 1'b1;
      default: ;
    endcase
  end

  assign hazard = (LOAD_USE_STALL != 0) && id_ex_reg.is_load &&
                  ((id_ex_reg.rd == id_rs) || (id_ex_reg.rd == id_rt));

  assign branch_taken = ((opcode == OP_BLT) && (branch_result == 2'b11)) ||
                        ((opcode == OP_BGT) && (branch_result == 2'b10)) ||
                        ((opcode == OP_BEQ) && (branch_result == 2'b01));

  // Decision order: overflow, halt opcode, load-use, branch/jump.
  always_comb begin
    state_next = state_reg;
    pc_op      = 1'b0;
    b_jmp      = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    stall      = 1'b0;
    bubble     = 1'b0;
    count_en   = 1'b0;
    if (reset) begin
      case (state_reg)
        ST_RUN: begin
          if (overflow_flag) begin
            state_next = ST_ERROR;
            if_flush   = 1'b1;
            id_flush   = 1'b1;
            bubble     = 1'b1;
          end else if (opcode == OP_HALT) begin
            state_next = ST_HALTED;
            if_flush   = 1'b1;
            id_flush   = 1'b1;
            bubble     = 1'b1;
          end else if (hazard) begin
            stall    = 1'b1;
            bubble   = 1'b1;
            count_en = 1'b1;
          end else if (branch_taken) begin
            pc_op    = 1'b1;
            b_jmp    = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
            bubble   = 1'b1;
          end else if (opcode == OP_JMP) begin
            pc_op    = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
          end
        end
        ST_HALTED: begin
          if_flush = 1'b1;
          id_flush = 1'b1;
          bubble   = 1'b1;
          if (overflow_flag)
            state_next = ST_ERROR;
          else if (resume)
            state_next = ST_RUN;
        end
        default: begin
          state_next = ST_ERROR;
          if_flush   = 1'b1;
          id_flush   = 1'b1;
          bubble     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_RUN;
      id_ex_reg    <= '0;
      ex_mem_reg   <= '0;
      mem_wb_reg   <= '0;
      halt_reg     <= 1'b0;
      warn_reg     <= 1'b0;
      ex_flush_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      halt_reg     <= (state_next != ST_RUN);
      warn_reg     <= (state_next == ST_ERROR);
      ex_flush_reg <= (state_next == ST_ERROR);
      if (state_next == ST_ERROR) begin
        id_ex_reg  <= '0;
        ex_mem_reg <= '0;
        mem_wb_reg <= '0;
      end else begin
        id_ex_reg  <= bubble ? '0 : decoded;
        ex_mem_reg <= {id_ex_reg.byte_en, id_ex_reg.mem_write, id_ex_reg.mux_c, id_ex_reg.reg_write};
        mem_wb_reg <= {ex_mem_reg.mux_c, ex_mem_reg.reg_write};
      end
      if (count_en && (count_reg != {CNT_W{1'b1}}))
        count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ex_flush               = ex_flush_reg;
  assign halt                   = halt_reg;
  assign overflow_error_warning = warn_reg;
  assign ex_alu_op              = id_ex_reg.alu_op;
  assign ex_alu_src_a           = id_ex_reg.alu_src_a;
  assign ex_alu_src_b           = id_ex_reg.alu_src_b;
  assign ex_r0_select           = id_ex_reg.r0_select;
  assign mem_byte_en            = ex_mem_reg.byte_en;
  assign mem_write              = ex_mem_reg.mem_write;
  assign wb_mux_c               = mem_wb_reg.mux_c;
  assign wb_reg_write           = mem_wb_reg.reg_write;
  assign stall_count            = count_reg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench: three instances (default, no load-use stall, 2-bit counter)
// driven in lockstep and checked against an instruction-level reference model.
module tb_pipe_ctrl_unit;

  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_ERR  = 2;

  typedef struct packed {
    logic       pc_op, b_jmp, if_flush, id_flush, stall, ex_flush, halt, warn;
    logic [1:0] ex_alu_op;
    logic       ex_src_a, ex_src_b, ex_r0;
    logic       mem_byte_en, mem_write;
    logic       wb_mux_c;
    logic [1:0] wb_reg_write;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_a, src_b, r0, byte_en, mem_write, mux_c;
    logic [1:0] reg_write;
    logic       is_load;
    logic [3:0] rd;
  } w_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = '0, function_code = '0, id_rs = '0, id_rt = '0, id_rd = '0;
  logic [1:0] branch_result = '0;
  logic       overflow_flag = 1'b0, resume = 1'b0;

  logic        dut_pc_op [3], dut_b_jmp [3], dut_if_flush [3], dut_id_flush [3], dut_stall [3];
  logic        dut_ex_flush [3], dut_halt [3], dut_warn [3];
  logic [1:0]  dut_ex_alu_op [3], dut_wb_reg_write [3];
  logic        dut_ex_src_a [3], dut_ex_src_b [3], dut_ex_r0 [3];
  logic        dut_mem_byte_en [3], dut_mem_write [3], dut_wb_mux_c [3];
  logic [15:0] dut_cnt [3];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int LS = (gi == 1) ? 0 : 1;
      localparam int CW = (gi == 2) ? 2 : 16;
      logic [CW-1:0] cnt_local;
      pipe_ctrl_unit #(.REG_AW(4), .CNT_W(CW), .LOAD_USE_STALL(LS)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .function_code(function_code),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_result(branch_result),
        .overflow_flag(overflow_flag), .resume(resume),
        .pc_op(dut_pc_op[gi]), .b_jmp(dut_b_jmp[gi]), .if_flush(dut_if_flush[gi]),
        .id_flush(dut_id_flush[gi]), .stall(dut_stall[gi]), .ex_flush(dut_ex_flush[gi]),
        .halt(dut_halt[gi]), .overflow_error_warning(dut_warn[gi]),
        .ex_alu_op(dut_ex_alu_op[gi]), .ex_alu_src_a(dut_ex_src_a[gi]),
        .ex_alu_src_b(dut_ex_src_b[gi]), .ex_r0_select(dut_ex_r0[gi]),
        .mem_byte_en(dut_mem_byte_en[gi]), .mem_write(dut_mem_write[gi]),
        .wb_mux_c(dut_wb_mux_c[gi]), .wb_reg_write(dut_wb_reg_write[gi]),
        .stall_count(cnt_local)
      );
      assign dut_cnt[gi] = 16'(cnt_local);
    end
  endgenerate

  // Reference model: per-instance mode, stall total and in-flight instruction list.
  int   ls [3]   = '{1, 0, 1};
  int   cmax [3] = '{65535, 65535, 3};
  int   mode [3];
  int   cnt [3];
  w_t   pipe_q [3][$];
  obs_t exp_q [3][$];
  int   compared = 0, mismatched = 0, cyc = 0;

  function automatic w_t model_decode(input logic [3:0] op, input logic [3:0] fn, input logic [3:0] rd);
    w_t w = '0;
    w.rd = rd;
    case (op)
      4'hF: begin
        w.alu_op = 2'b01; w.mux_c = 1'b1;
        w.reg_write = (fn == 4'h8 || fn == 4'h4) ? 2'b11 : (fn == 4'h1 || fn == 4'h2) ? 2'b10 : 2'b00;
      end
      4'h1: begin w.alu_op = 2'b00; w.src_b = 1'b1; w.reg_write = 2'b10; w.mux_c = 1'b1; end
      4'h2: begin w.alu_op = 2'b10; w.src_b = 1'b1; w.reg_write = 2'b10; w.mux_c = 1'b1; end
      4'hA: begin w.alu_op = 2'b11; w.src_a = 1'b1; w.reg_write = 2'b10; w.is_load = 1'b1; w.byte_en = 1'b1; end
      4'hC: begin w.alu_op = 2'b11; w.src_a = 1'b1; w.reg_write = 2'b10; w.is_load = 1'b1; end
      4'hB: begin w.alu_op = 2'b11; w.src_a = 1'b1; w.mem_write = 1'b1; w.byte_en = 1'b1; end
      4'hD: begin w.alu_op = 2'b11; w.src_a = 1'b1; w.mem_write = 1'b1; end
      4'h4, 4'h5, 4'h6: w.r0 = 1'b1;
      default: ;
    endcase
    return w;
  endfunction

  task automatic model_reset(input int k);
    mode[k] = M_RUN;
    cnt[k]  = 0;
    pipe_q[k].delete();
    repeat (3) pipe_q[k].push_back('0);
  endtask

  task automatic model_cycle(input int k);
    obs_t e;
    w_t   d, ex_w, nw;
    logic bub, stl, taken, hz;
    e    = '0;
    ex_w = pipe_q[k][0];
    e.ex_alu_op    = ex_w.alu_op;
    e.ex_src_a     = ex_w.src_a;
    e.ex_src_b     = ex_w.src_b;
    e.ex_r0        = ex_w.r0;
    e.mem_byte_en  = pipe_q[k][1].byte_en;
    e.mem_write    = pipe_q[k][1].mem_write;
    e.wb_mux_c     = pipe_q[k][2].mux_c;
    e.wb_reg_write = pipe_q[k][2].reg_write;
    e.halt         = (mode[k] != M_RUN);
    e.warn         = (mode[k] == M_ERR);
    e.ex_flush     = (mode[k] == M_ERR);
    e.cnt          = 16'(cnt[k]);
    d     = model_decode(opcode, function_code, id_rd);
    taken = (opcode == 4'h5 && branch_result == 2'b11) || (opcode == 4'h4 && branch_result == 2'b10) ||
            (opcode == 4'h6 && branch_result == 2'b01);
    hz    = (ls[k] != 0) && ex_w.is_load && (ex_w.rd == id_rs || ex_w.rd == id_rt);
    bub = 1'b0;
    stl = 1'b0;
    if (reset) begin
      if (mode[k] != M_RUN || overflow_flag || opcode == 4'h0) begin
        e.if_flush = 1'b1; e.id_flush = 1'b1; bub = 1'b1;
      end else if (hz) begin
        e.stall = 1'b1; stl = 1'b1; bub = 1'b1;
      end else if (taken) begin
        e.pc_op = 1'b1; e.b_jmp = 1'b1; e.if_flush = 1'b1; e.id_flush = 1'b1; bub = 1'b1;
      end else if (opcode == 4'h7) begin
        e.pc_op = 1'b1; e.if_flush = 1'b1; e.id_flush = 1'b1;
      end
    end
    exp_q[k].push_back(e);
    if (!reset) begin
      model_reset(k);
    end else if (mode[k] == M_ERR || overflow_flag) begin
      mode[k] = M_ERR;
      pipe_q[k].delete();
      repeat (3) pipe_q[k].push_back('0);
    end else begin
      if (bub) nw = '0;
      else nw = d;
      pipe_q[k].push_front(nw);
      void'(pipe_q[k].pop_back());
      if (mode[k] == M_RUN && opcode == 4'h0) mode[k] = M_HALT;
      else if (mode[k] == M_HALT && resume) mode[k] = M_RUN;
      if (stl && cnt[k] < cmax[k]) cnt[k]++;
    end
  endtask

  task automatic step(input logic [3:0] op, input logic [3:0] fn, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [3:0] rd, input logic [1:0] br,
                      input logic ovf, input logic res, input logic rst);
    @(posedge clk);
    #1;
    opcode = op; function_code = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    branch_result = br; overflow_flag = ovf; resume = res; reset = rst;
    cyc++;
    for (int k = 0; k < 3; k++) model_cycle(k);
    $display("cyc %0d rst=%0b op=%h fn=%h rs=%0d rt=%0d rd=%0d br=%b ovf=%0b res=%0b",
             cyc, rst, op, fn, rs, rt, rd, br, ovf, res);
  endtask

  function automatic obs_t get_obs(input int k);
    obs_t a;
    a.pc_op = dut_pc_op[k];       a.b_jmp = dut_b_jmp[k];
    a.if_flush = dut_if_flush[k]; a.id_flush = dut_id_flush[k];
    a.stall = dut_stall[k];       a.ex_flush = dut_ex_flush[k];
    a.halt = dut_halt[k];         a.warn = dut_warn[k];
    a.ex_alu_op = dut_ex_alu_op[k];
    a.ex_src_a = dut_ex_src_a[k]; a.ex_src_b = dut_ex_src_b[k]; a.ex_r0 = dut_ex_r0[k];
    a.mem_byte_en = dut_mem_byte_en[k]; a.mem_write = dut_mem_write[k];
    a.wb_mux_c = dut_wb_mux_c[k]; a.wb_reg_write = dut_wb_reg_write[k];
    a.cnt = dut_cnt[k];
    return a;
  endfunction

  task automatic check_reset_state();
    obs_t a;
    #2;
    for (int k = 0; k < 3; k++) begin
      a = get_obs(k);
      compared++;
      if (a !== '0) begin
        mismatched++;
        $display("FAIL reset state dut%0d cyc %0d: got %h required all zero", k, cyc, a);
      end else begin
        $display("reset state dut%0d cyc %0d: all outputs zero", k, cyc);
      end
    end
  endtask

  obs_t mon_exp, mon_act;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (exp_q[k].size() > 0) begin
        mon_exp = exp_q[k].pop_front();
        mon_act = get_obs(k);
        compared++;
        if (mon_act !== mon_exp) begin
          mismatched++;
          $display("FAIL outputs dut%0d cyc %0d: got %h required %h (pc,bj,iff,idf,stl,exf,hlt,warn|alu,sa,sb,r0|be,mw|mc,rw|cnt)",
                   k, cyc, mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    mismatched++;
    $display("FAIL timeout: stimulus did not finish by %0t (cyc %0d)", $time, cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    for (int k = 0; k < 3; k++) model_reset(k);
    // Reset then A-type flowing to WB
    step(4'hF, 4'h8, 0, 0, 0, 0, 0, 0, 0);
    step(4'hF, 4'h8, 0, 0, 0, 0, 0, 0, 0);
    check_reset_state();
    step(4'hF, 4'h8, 0, 0, 1, 0, 0, 0, 1);
    repeat (4) step(4'h3, 0, 0, 0, 0, 0, 0, 0, 1);
    // Load-use via rs, then via rt
    step(4'hC, 0, 0, 0, 3, 0, 0, 0, 1);
    step(4'hF, 4'h1, 3, 0, 5, 0, 0, 0, 1);
    step(4'hF, 4'h1, 3, 0, 5, 0, 0, 0, 1);
    step(4'hA, 0, 0, 0, 2, 0, 0, 0, 1);
    step(4'hD, 0, 1, 2, 0, 0, 0, 0, 1);
    step(4'hD, 0, 1, 2, 0, 0, 0, 0, 1);
    repeat (3) step(4'h3, 0, 0, 0, 0, 0, 0, 0, 1);
    // Branches and jump
    step(4'h5, 0, 0, 0, 0, 2'b11, 0, 0, 1);
    step(4'h5, 0, 0, 0, 0, 2'b10, 0, 0, 1);
    step(4'h6, 0, 0, 0, 0, 2'b01, 0, 0, 1);
    step(4'h4, 0, 0, 0, 0, 2'b10, 0, 0, 1);
    step(4'h4, 0, 0, 0, 0, 2'b01, 0, 0, 1);
    step(4'h7, 0, 0, 0, 0, 0, 0, 0, 1);
    step(4'h3, 0, 0, 0, 0, 0, 0, 0, 1);
    // sw drains through a halt; resume after 5 cycles
    step(4'hD, 0, 0, 0, 0, 0, 0, 0, 1);
    step(4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) step(4'hF, 4'h8, 0, 0, 0, 0, 0, 0, 1);
    step(4'hF, 4'h8, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) step(4'h3, 0, 0, 0, 0, 0, 0, 0, 1);
    // Back-to-back hazards (2-bit counter saturates)
    repeat (11) step(4'hC, 0, 3, 3, 3, 0, 0, 0, 1);
    // Halt opcode coincides with a load-use hazard
    step(4'hC, 0, 0, 0, 5, 0, 0, 0, 1);
    step(4'h0, 0, 5, 5, 0, 0, 0, 0, 1);
    step(4'h3, 0, 0, 0, 0, 0, 0, 1, 1);
    step(4'h3, 0, 0, 0, 0, 0, 0, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 79) != 0));
    end
    step(4'h3, 0, 0, 0, 0, 0, 0, 1, 1);
    step(4'h3, 0, 0, 0, 0, 0, 0, 0, 1);
    // Overflow while halted: sticky error, resume ignored, reset recovers
    step(4'hC, 0, 0, 0, 1, 0, 0, 0, 1);
    step(4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(4'hF, 4'h8, 0, 0, 0, 0, 0, 0, 1);
    step(4'hF, 4'h8, 0, 0, 0, 0, 1, 0, 1);
    repeat (3) step(4'hF, 4'h8, 0, 0, 0, 0, 0, 1, 1);
    step(4'hF, 4'h8, 0, 0, 0, 0, 1, 1, 0);
    repeat (4) step(4'hF, 4'h8, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
